// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with valid/ready handshakes, branch resolve and forwarding port
// Optional 2-entry skid buffer enabled by defining EX_MEM_SKID_EN.
module ex_mem_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ExValid,
  output logic        ExReady,
  input  logic        Flush,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  input  logic [31:0] StoreData,
  input  logic [4:0]  WriteReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        Branch,
  input  logic        BranchNE,
  input  logic [31:0] BranchTarget,
  output logic        MemValid,
  input  logic        MemReady,
  output logic [31:0] MemAddr,
  output logic [31:0] MemStoreData,
  output logic [4:0]  MemWriteReg,
  output logic        MemRegWrite,
  output logic        MemMemRead,
  output logic        MemMemWrite,
  output logic        MemMemToReg,
  output logic        PCSrc,
  output logic [31:0] BranchAddr,
  output logic        FwdValid,
  output logic [4:0]  FwdReg,
  output logic [31:0] FwdData
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int ENTRY_W = 32 + 32 + 5 + 4;

  logic [1:0]         occ;
  logic [1:0]         occ_next;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] in_entry;
  logic               accept;
  logic               pop;
  logic               taken;
  logic               pcsrc_q;
  logic [31:0]        branch_addr_q;

  // Branch itself is not stored; only the fields the memory stage needs.
  assign in_entry = {ALUResult, StoreData, WriteReg, RegWrite, MemRead, MemWrite, MemToReg};

  assign MemValid = (occ != OCC_EMPTY);
  assign accept   = ExValid & ExReady & ~Flush;
  assign pop      = MemValid & MemReady;
  assign taken    = accept & Branch & (Zero ^ BranchNE);

`ifdef EX_MEM_SKID_EN
  logic [ENTRY_W-1:0] skid;
  logic               ready_q;

  // Registered ready keeps MemReady off the EX-side timing path.
  assign ExReady = ready_q;

  always_comb begin
    occ_next = occ;
    case (occ)
      OCC_EMPTY: begin
        if (accept) occ_next = OCC_ONE;
      end
      OCC_ONE: begin
        if (accept && !pop) occ_next = OCC_TWO;
        else if (!accept && pop) occ_next = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (pop) occ_next = OCC_ONE;
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      occ     <= OCC_EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b1;
    end else begin
      occ     <= occ_next;
      ready_q <= (occ_next != OCC_TWO);
      case (occ)
        OCC_EMPTY: begin
          if (accept) head <= in_entry;
        end
        OCC_ONE: begin
          if (accept && pop) head <= in_entry;
          else if (accept) skid <= in_entry;
        end
        OCC_TWO: begin
          if (pop) head <= skid;
        end
        default: ;
      endcase
    end
  end
`else
  assign ExReady = ~MemValid | MemReady;

  always_comb begin
    occ_next = occ;
    if (accept) occ_next = OCC_ONE;
    else if (pop) occ_next = OCC_EMPTY;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
    end else begin
      occ <= occ_next;
      if (accept) head <= in_entry;
    end
  end
`endif

  assign {MemAddr, MemStoreData, MemWriteReg,
          MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg} = head;

  // Loads are excluded: their data is not known until the memory stage returns it.
  assign FwdValid = MemValid & MemRegWrite & ~MemMemToReg & (MemWriteReg != 5'd0);
  assign FwdReg   = MemWriteReg;
  assign FwdData  = MemAddr;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pcsrc_q       <= 1'b0;
      branch_addr_q <= '0;
    end else begin
      pcsrc_q <= taken;
      if (taken) branch_addr_q <= BranchTarget;
    end
  end

  assign PCSrc      = pcsrc_q;
  assign BranchAddr = branch_addr_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard testbench for ex_mem_stage (EX_MEM_SKID_EN aware)
module tb_ex_mem_stage;

  logic        Clk;
  logic        Rst;
  logic        ExValid;
  logic        ExReady;
  logic        Flush;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [31:0] StoreData;
  logic [4:0]  WriteReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        Branch;
  logic        BranchNE;
  logic [31:0] BranchTarget;
  logic        MemValid;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [31:0] MemStoreData;
  logic [4:0]  MemWriteReg;
  logic        MemRegWrite;
  logic        MemMemRead;
  logic        MemMemWrite;
  logic        MemMemToReg;
  logic        PCSrc;
  logic [31:0] BranchAddr;
  logic        FwdValid;
  logic [4:0]  FwdReg;
  logic [31:0] FwdData;

  ex_mem_stage dut (
    .Clk(Clk), .Rst(Rst), .ExValid(ExValid), .ExReady(ExReady), .Flush(Flush),
    .ALUResult(ALUResult), .Zero(Zero), .StoreData(StoreData), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .Branch(Branch), .BranchNE(BranchNE), .BranchTarget(BranchTarget),
    .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemStoreData(MemStoreData),
    .MemWriteReg(MemWriteReg), .MemRegWrite(MemRegWrite), .MemMemRead(MemMemRead),
    .MemMemWrite(MemMemWrite), .MemMemToReg(MemMemToReg), .PCSrc(PCSrc),
    .BranchAddr(BranchAddr), .FwdValid(FwdValid), .FwdReg(FwdReg), .FwdData(FwdData)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } ent_t;

  ent_t        exp_q[$];
  int          cnt;
  logic        exp_pcsrc;
  logic [31:0] exp_baddr;
  bit          mon_en;
  int          checks;
  int          failures;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input logic mrdy);
`ifdef EX_MEM_SKID_EN
    return cnt < 2;
`else
    return (cnt == 0) || (mrdy == 1'b1);
`endif
  endfunction

  // Head-of-stage monitor: compares whatever the DUT presents against the oldest expected entry.
  always @(negedge Clk) begin
    if (mon_en && MemValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("head_unexpected", 32'd1, 32'd0);
      end else begin
        ent_t e;
        e = exp_q[0];
        chk("mem_addr", MemAddr, e.addr);
        chk("mem_store_data", MemStoreData, e.sd);
        chk("mem_write_reg", {27'd0, MemWriteReg}, {27'd0, e.wr});
        chk("mem_ctrl", {28'd0, MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg},
            {28'd0, e.rw, e.mr, e.mw, e.m2r});
        chk("fwd_valid", {31'd0, FwdValid}, {31'd0, e.rw && !e.m2r && (e.wr != 5'd0)});
        chk("fwd_reg", {27'd0, FwdReg}, {27'd0, e.wr});
        chk("fwd_data", FwdData, e.addr);
        if (MemReady === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    ExValid = 0; Flush = 0; ALUResult = '0; Zero = 0; StoreData = '0; WriteReg = '0;
    RegWrite = 0; MemRead = 0; MemWrite = 0; MemToReg = 0; Branch = 0; BranchNE = 0;
    BranchTarget = '0;
  endtask

  task automatic offer(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic br, input logic bne, input logic z, input logic [31:0] tgt);
    ExValid = 1; Flush = 0; ALUResult = alu; StoreData = sd; WriteReg = wr;
    RegWrite = rw; MemRead = mr; MemWrite = mw; MemToReg = m2r;
    Branch = br; BranchNE = bne; Zero = z; BranchTarget = tgt;
  endtask

  // One clock of stimulus: model decides accept/pop, checks at negedge, advances after the edge.
  task automatic run_cycle(output bit acc);
    bit rdy, pop, tk;
    logic [31:0] tgt;
    ent_t e;
    rdy = exp_ready(MemReady);
    acc = (ExValid === 1'b1) && rdy && (Flush !== 1'b1);
    pop = (cnt > 0) && (MemReady === 1'b1);
    tk  = acc && Branch && (Zero != BranchNE);
    tgt = BranchTarget;
    if (acc) begin
      e.addr = ALUResult; e.sd = StoreData; e.wr = WriteReg;
      e.rw = RegWrite; e.mr = MemRead; e.mw = MemWrite; e.m2r = MemToReg;
      exp_q.push_back(e);
    end
    @(negedge Clk);
    chk("ex_ready", {31'd0, ExReady}, {31'd0, rdy});
    chk("mem_valid", {31'd0, MemValid}, {31'd0, cnt > 0});
    chk("pcsrc", {31'd0, PCSrc}, {31'd0, exp_pcsrc});
    chk("branch_addr", BranchAddr, exp_baddr);
    if (cnt == 0) chk("fwd_valid_empty", {31'd0, FwdValid}, 32'd0);
    @(posedge Clk);
    #1;
    cnt = cnt - int'(pop) + int'(acc);
    exp_pcsrc = tk;
    if (tk) exp_baddr = tgt;
  endtask

  task automatic reset_dut(input int n);
    mon_en = 0;
    Rst = 0;
    MemReady = 0;
    idle_inputs();
    repeat (n) @(posedge Clk);
    #1;
    cnt = 0;
    exp_q.delete();
    exp_pcsrc = 0;
    exp_baddr = '0;
    @(negedge Clk);
    chk("rst_mem_valid", {31'd0, MemValid}, 32'd0);
    chk("rst_ex_ready", {31'd0, ExReady}, 32'd1);
    chk("rst_pcsrc", {31'd0, PCSrc}, 32'd0);
    chk("rst_branch_addr", BranchAddr, 32'd0);
    chk("rst_mem_addr", MemAddr, 32'd0);
    chk("rst_store_data", MemStoreData, 32'd0);
    chk("rst_fields", {22'd0, MemWriteReg, MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg,
                       FwdValid}, 32'd0);
    Rst = 1;
    @(posedge Clk);
    #1;
    mon_en = 1;
  endtask

  initial begin
    bit acc;
    int idx;
    logic [31:0] sw_addr [3];
    checks = 0;
    failures = 0;
    cnt = 0;
    exp_pcsrc = 0;
    exp_baddr = '0;
    mon_en = 0;
    Rst = 0;
    MemReady = 0;
    idle_inputs();

    reset_dut(2);

    // ADD streamed straight through
    MemReady = 1;
    offer(32'h10, 32'h0, 5'd8, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    run_cycle(acc);
    idle_inputs();
    run_cycle(acc);

    // BEQ taken, then BNE with Zero=1 not taken
    offer(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 0, 1, 32'h0040_0040);
    run_cycle(acc);
    idle_inputs();
    run_cycle(acc);
    offer(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 1, 32'h0040_0080);
    run_cycle(acc);
    idle_inputs();
    run_cycle(acc);
    run_cycle(acc);

    // Memory stall with three stores offered, released after four cycles
    sw_addr[0] = 32'h100; sw_addr[1] = 32'h104; sw_addr[2] = 32'h108;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      MemReady = (c >= 4);
      if (idx < 3) offer(sw_addr[idx], 32'hA000 + idx, 5'd0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
      else idle_inputs();
      run_cycle(acc);
      if (acc) idx++;
    end
    chk("stall_all_accepted", idx, 3);

    // Flushed taken branch: nothing captured, no PCSrc
    MemReady = 0;
    offer(32'h200, 32'h0, 5'd3, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    run_cycle(acc);
    offer(32'h300, 32'h0, 5'd0, 0, 0, 0, 0, 1, 0, 1, 32'h0050_0000);
    Flush = 1;
    run_cycle(acc);
    idle_inputs();
    run_cycle(acc);
    MemReady = 1;
    run_cycle(acc);
    run_cycle(acc);

    // Reset in the middle of a stall, with a branch pulse pending
    MemReady = 0;
    offer(32'h400, 32'h1, 5'd4, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    run_cycle(acc);
    offer(32'h404, 32'h2, 5'd5, 1, 0, 0, 0, 1, 0, 1, 32'h0060_0000);
    run_cycle(acc);
    reset_dut(1);

    // Forwarding suppression: load, then write to $zero, then a normal write
    MemReady = 1;
    offer(32'h500, 32'h0, 5'd9, 1, 1, 0, 1, 0, 0, 0, 32'h0);
    run_cycle(acc);
    offer(32'h504, 32'h0, 5'd0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    run_cycle(acc);
    offer(32'h508, 32'h0, 5'd7, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    run_cycle(acc);
    idle_inputs();
    run_cycle(acc);

    // Randomized traffic with random backpressure, flushes and branches
    for (int c = 0; c < 3000; c++) begin
      MemReady = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) begin
        offer($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
              1'($urandom), $urandom);
        Flush = ($urandom_range(0, 7) == 0);
      end else begin
        idle_inputs();
      end
      run_cycle(acc);
    end

    idle_inputs();
    MemReady = 1;
    repeat (4) run_cycle(acc);
    chk("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage that captures each ALU32Bit result (ALUResult, Zero) together with the instruction's store data, destination register and memory/writeback controls, and presents them to the data-memory stage. Transfers on both sides use valid/ready handshakes. An optional skid entry keeps EX running for one cycle while memory stalls. The stage resolves BEQ/BNE from Zero, producing a registered one-cycle PCSrc pulse, and drives a forwarding port toward the EX operand muxes.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register index.
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-low
- ExValid  in  1  EX holds a valid instruction
- ExReady  out  1  stage can accept this cycle
- Flush  in  1  kill the EX instruction offered this cycle
- ALUResult  in  32  ALU output / memory address
- Zero  in  1  ALU zero flag
- StoreData  in  32  rt value for SW
- WriteReg  in  5  destination register
- RegWrite, MemRead, MemWrite, MemToReg  in  1 each  control bits
- Branch, BranchNE  in  1 each  BEQ (Branch=1, BranchNE=0); BNE (both 1)
- BranchTarget  in  32  computed target
- MemValid  out  1  head entry valid
- MemReady  in  1  memory stage consumes head this cycle
- MemAddr, MemStoreData  out  32 each  head ALUResult / StoreData
- MemWriteReg  out  5; MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg  out  1 each  head fields
- PCSrc  out  1  taken-branch pulse
- BranchAddr  out  32  target accompanying PCSrc
- FwdValid  out  1  MemValid & MemRegWrite & ~MemMemToReg & (MemWriteReg≠0)
- FwdReg  out  5  = MemWriteReg
- FwdData  out  32  = MemAddr

## Operation
- Accept = ExValid & ExReady & ~Flush. Pop = MemValid & MemReady.
- With EX_MEM_SKID_EN, occupancy is EMPTY, ONE or TWO (head + skid).
  - EMPTY, Accept → ONE.
  - ONE, Accept & ~Pop → TWO (incoming entry goes to skid).
  - ONE, Accept & Pop → ONE (head replaced by incoming).
  - ONE, Pop only → EMPTY.
  - TWO, Pop → ONE (skid moves to head). The head input is not accepted in TWO, because ExReady=0.
- Branch entries are stored like any other entry. Controls are passed through unmodified; Branch is not stored.
- Taken = Accept & Branch & (Zero ^ BranchNE). On Taken, at the next edge PCSrc=1 and BranchAddr=BranchTarget; otherwise PCSrc=0.
- BranchAddr holds its last value when PCSrc=0.
- Flush with ExValid: nothing is captured, and no PCSrc is generated for that instruction. Existing entries are unaffected.
- Memory outputs reflect the head and are meaningful only while MemValid=1. Data fields hold their value when the stage is empty.

## Timing
- Rst low at an edge: occupancy EMPTY, MemValid=0, PCSrc=0. All data/control outputs and BranchAddr are 0. ExReady=1 (registered, skid build).
- Latency: an instruction accepted at edge N is MemValid at N (visible in cycle N+1). The PCSrc pulse is in the same cycle and is exactly 1 cycle wide.
- Skid build: ExReady is registered and equals (occupancy≠TWO).
  - It drops in the cycle after entering TWO.
  - It rises in the cycle after a Pop from TWO.
- Rst low mid-stall discards both entries and any pending PCSrc.
- MemValid with its fields must stay stable until Pop.

## Configuration
- EX_MEM_SKID_EN defined: 2-entry skid buffer as above; ExReady is registered and has no combinational path from MemReady.
- EX_MEM_SKID_EN undefined: single entry; ExReady = ~MemValid | MemReady (combinational).
  - ONE with Accept & Pop replaces the head.
  - States reduce to EMPTY/ONE. All other behaviour is identical.

## Test plan
- Reset then stream: Rst=0 for 2 cycles, then ADD with ALUResult=0x00000010, WriteReg=8, RegWrite=1, MemReady=1. Expect MemValid=1 at the next edge, MemAddr=0x10, FwdValid=1, FwdReg=8, FwdData=0x10.
- BEQ: Zero=1, BranchTarget=0x00400040. Expect PCSrc=1 for one cycle with BranchAddr=0x00400040. BNE with Zero=1 gives PCSrc=0.
- Memory stall (skid build): MemReady=0 while 3 SWs are offered. Expect 2 accepted and ExReady=0 from the cycle after the second. Releasing MemReady delivers them in order (0x100, 0x104), then the third.
- Flush: ExValid=1, Flush=1, Branch=1, Zero=1. Expect no capture, PCSrc=0, MemValid unchanged.
- Reset mid-stall: occupancy TWO, then Rst=0 for one edge. Expect MemValid=0, ExReady=1, PCSrc=0, all fields 0.
- Forward suppression: LW with WriteReg=9 gives FwdValid=0. ADD with WriteReg=0 gives FwdValid=0.
